// File: rtl/wb_led_sequencer.sv
// Autonomous Wishbone classic master that steps the LED register through walk, bounce,
// blink and binary-count patterns, with optional read-back verify and sticky error flags.
module wb_led_sequencer #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned           LED_WIDTH    = 6,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned           TICK_WIDTH   = 24,
    parameter int unsigned           TIMEOUT      = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic [1:0]              i_mode,
    input  logic [TICK_WIDTH-1:0]   i_period,
    input  logic                    i_verify,
    input  logic                    i_err_clr,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_we_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    o_busy,
    output logic [LED_WIDTH-1:0]    o_pattern,
    output logic                    o_err,
    output logic [1:0]              o_err_code
);

    localparam int unsigned TmoWidth = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ModeWalk   = 2'd0;
    localparam logic [1:0] ModeBounce = 2'd1;
    localparam logic [1:0] ModeBlink  = 2'd2;
    localparam logic [1:0] ModeCount  = 2'd3;

    localparam logic [1:0] ErrBus     = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;
    localparam logic [1:0] ErrVerify  = 2'b11;

    localparam logic [LED_WIDTH-1:0] LedOnes = '1;

    typedef enum logic [1:0] {StIdle, StWr, StRd, StWait} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic                    verify_q, verify_d;
    logic [LED_WIDTH-1:0]    pat_q, pat_d, pat_next;
    logic                    dir_up_q, dir_up_d, dir_up_next;
    logic                    blink_on_q, blink_on_d;
    logic [TICK_WIDTH-1:0]   tick_q, tick_d;
    logic [TmoWidth-1:0]     tmo_q, tmo_d;
    logic [LED_WIDTH-1:0]    led_q, led_d;
    logic                    err_q, err_d;
    logic [1:0]              code_q, code_d;

    logic [TICK_WIDTH-1:0]   period_eff;
    logic                    tmo_hit;
    logic                    unused_dat_hi;

    assign period_eff    = (i_period == '0) ? TICK_WIDTH'(1) : i_period;
    assign tmo_hit       = (tmo_q == TmoWidth'(TIMEOUT - 1));
    assign unused_dat_hi = ^wb_dat_i[DATA_WIDTH-1:LED_WIDTH];

    // Pattern step; blink only toggles its phase bit, handled in the FSM.
    always_comb begin
        pat_next    = pat_q;
        dir_up_next = dir_up_q;
        unique case (mode_q)
            ModeWalk:  pat_next = {pat_q[LED_WIDTH-2:0], pat_q[LED_WIDTH-1]};
            ModeBounce: begin
                if (dir_up_q) begin
                    if (pat_q[LED_WIDTH-1]) begin
                        dir_up_next = 1'b0;
                        pat_next    = pat_q >> 1;
                    end else begin
                        pat_next    = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        dir_up_next = 1'b1;
                        pat_next    = pat_q << 1;
                    end else begin
                        pat_next    = pat_q >> 1;
                    end
                end
            end
            ModeCount: pat_next = pat_q + LED_WIDTH'(1);
            default:   ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            verify_q   <= 1'b0;
            pat_q      <= '0;
            dir_up_q   <= 1'b0;
            blink_on_q <= 1'b0;
            tick_q     <= '0;
            tmo_q      <= '0;
            led_q      <= '0;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            verify_q   <= verify_d;
            pat_q      <= pat_d;
            dir_up_q   <= dir_up_d;
            blink_on_q <= blink_on_d;
            tick_q     <= tick_d;
            tmo_q      <= tmo_d;
            led_q      <= led_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        verify_d   = verify_q;
        pat_d      = pat_q;
        dir_up_d   = dir_up_q;
        blink_on_d = blink_on_q;
        tick_d     = tick_q;
        tmo_d      = tmo_q;
        led_d      = led_q;
        err_d      = err_q;
        code_d     = code_q;
        unique case (state_q)
            StIdle: begin
                if (i_err_clr) begin
                    err_d  = 1'b0;
                    code_d = 2'b00;
                end
                if (i_enable && !err_q) begin
                    state_d    = StWr;
                    mode_d     = i_mode;
                    verify_d   = i_verify;
                    pat_d      = (i_mode == ModeCount) ? '0 : LED_WIDTH'(1);
                    dir_up_d   = 1'b1;
                    blink_on_d = 1'b1;
                    tmo_d      = '0;
                end
            end
            StWr: begin
                tmo_d = tmo_q + TmoWidth'(1);
                if (wb_err_i) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    code_d  = ErrBus;
                end else if (wb_ack_i) begin
                    if (mode_q == ModeBlink) led_d = blink_on_q ? LedOnes : '0;
                    else                     led_d = pat_q;
                    if (verify_q && (mode_q != ModeBlink)) begin
                        state_d = StRd;
                        tmo_d   = '0;
                    end else begin
                        state_d = StWait;
                        tick_d  = period_eff;
                    end
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    code_d  = ErrTimeout;
                end
            end
            StRd: begin
                tmo_d = tmo_q + TmoWidth'(1);
                if (wb_err_i) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    code_d  = ErrBus;
                end else if (wb_ack_i) begin
                    if (wb_dat_i[LED_WIDTH-1:0] != pat_q) begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                        code_d  = ErrVerify;
                    end else begin
                        state_d = StWait;
                        tick_d  = period_eff;
                    end
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    code_d  = ErrTimeout;
                end
            end
            StWait: begin
                if (!i_enable) begin
                    state_d = StIdle;
                end else if (tick_q <= TICK_WIDTH'(1)) begin
                    state_d    = StWr;
                    pat_d      = pat_next;
                    dir_up_d   = dir_up_next;
                    blink_on_d = ~blink_on_q;
                    tmo_d      = '0;
                end else begin
                    tick_d = tick_q - TICK_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus signals decode straight from state so reset drops cyc/stb asynchronously.
    always_comb begin
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_we_o  = 1'b0;
        wb_sel_o = '0;
        wb_stb_o = 1'b0;
        wb_cyc_o = 1'b0;
        unique case (state_q)
            StWr: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_sel_o = '1;
                if (mode_q == ModeBlink) begin
                    wb_adr_o = BASE_ADDR + (blink_on_q ? ADDR_WIDTH'(4) : ADDR_WIDTH'(8));
                    wb_dat_o = DATA_WIDTH'(LedOnes);
                end else begin
                    wb_adr_o = BASE_ADDR;
                    wb_dat_o = DATA_WIDTH'(pat_q);
                end
            end
            StRd: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_sel_o = '1;
                wb_adr_o = BASE_ADDR;
            end
            default: ;
        endcase
    end

    assign o_busy     = (state_q != StIdle);
    assign o_pattern  = led_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;

endmodule

// File: tb/tb_wb_led_sequencer.sv
// Randomized scoreboard bench for wb_led_sequencer: expected bus transactions are queued at
// stimulus time and a negedge monitor pops and compares each acknowledged transaction.
module tb_wb_led_sequencer;

    localparam int To = 15;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [5:0]  led;
        int          gap;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] period = 24'd1;
    logic        verify = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] adr, dat_o, dat_i;
    logic        we, stb, cyc;
    logic [3:0]  sel;
    logic        ack, berr;
    logic        busy, err;
    logic [5:0]  pat;
    logic [1:0]  code;

    int   total = 0;
    int   bad = 0;
    txn_t exq[$];
    txn_t mon_e;

    int         slv_mode = 0;   // 0 ack, 1 never respond, 2 bus error
    logic       corrupt = 1'b0;
    logic [5:0] mem;

    int   low_cnt = 0;
    int   last_gap = 0;
    logic prev_cyc = 1'b0;

    always #5 clk = ~clk;

    wb_led_sequencer dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (en),
        .i_mode     (mode),
        .i_period   (period),
        .i_verify   (verify),
        .i_err_clr  (err_clr),
        .wb_adr_o   (adr),
        .wb_dat_o   (dat_o),
        .wb_dat_i   (dat_i),
        .wb_we_o    (we),
        .wb_sel_o   (sel),
        .wb_stb_o   (stb),
        .wb_cyc_o   (cyc),
        .wb_ack_i   (ack),
        .wb_err_i   (berr),
        .o_busy     (busy),
        .o_pattern  (pat),
        .o_err      (err),
        .o_err_code (code)
    );

    // LED slave: set / set-bits / clear-bits registers, ack one cycle after stb.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack  <= 1'b0;
            berr <= 1'b0;
            mem  <= 6'd0;
        end else begin
            ack  <= 1'b0;
            berr <= 1'b0;
            if (cyc && stb && !ack && !berr) begin
                if (slv_mode == 0) begin
                    ack <= 1'b1;
                    if (we) begin
                        case (adr)
                            32'd0:   mem <= dat_o[5:0];
                            32'd4:   mem <= mem | dat_o[5:0];
                            32'd8:   mem <= mem & ~dat_o[5:0];
                            default: ;
                        endcase
                    end
                end else if (slv_mode == 2) begin
                    berr <= 1'b1;
                end
            end
        end
    end
    assign dat_i = (corrupt && mem == 6'h04) ? 32'h0 : {26'h0, mem};

    always @(negedge clk) begin
        if (!cyc) low_cnt <= low_cnt + 1;
        else begin
            if (!prev_cyc) last_gap <= low_cnt;
            low_cnt <= 0;
        end
        prev_cyc <= cyc;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always begin
        @(negedge clk);
        if (cyc && stb && ack) begin
            if (exq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_txn: got we=%0b adr=%0h dat=%0h want none", we, adr,
                         dat_o);
            end else begin
                mon_e = exq.pop_front();
                check("txn_we", {31'd0, we}, {31'd0, mon_e.we});
                check("txn_adr", adr, mon_e.adr);
                check("txn_sel", {28'd0, sel}, 32'hF);
                if (mon_e.we) begin
                    check("wr_dat", dat_o, mon_e.dat);
                    if (mon_e.gap >= 0) check("step_gap", last_gap, mon_e.gap);
                    @(negedge clk);
                    check("o_pattern", {26'd0, pat}, {26'd0, mon_e.led});
                end
            end
        end
    end

    // Reference model: the k-th write of a run straight from the pattern definitions.
    function automatic txn_t exp_write(input int m, input int k, input int p);
        txn_t t;
        int   idx;
        t.we  = 1'b1;
        t.gap = (k == 0) ? -1 : ((p == 0) ? 1 : p);
        t.adr = 32'd0;
        case (m)
            0: t.led = 6'(1 << (k % 6));
            1: begin
                idx   = k % 10;
                t.led = 6'(1 << ((idx <= 5) ? idx : 10 - idx));
            end
            2: begin
                t.adr = (k % 2 == 0) ? 32'd4 : 32'd8;
                t.led = (k % 2 == 0) ? 6'h3F : 6'h00;
            end
            default: t.led = 6'(k % 64);
        endcase
        t.dat = (m == 2) ? 32'h3F : {26'h0, t.led};
        return t;
    endfunction

    function automatic txn_t exp_read();
        txn_t t;
        t.we  = 1'b0;
        t.adr = 32'd0;
        t.dat = 32'd0;
        t.led = 6'd0;
        t.gap = -1;
        return t;
    endfunction

    task automatic wait_q_empty(input string nm, input int budget);
        int n = 0;
        while (exq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exq.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d pending txns want 0", nm, exq.size());
            exq.delete();
        end
    endtask

    task automatic wait_busy_low(input string nm, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_stb(input string nm, input int budget);
        int n = 0;
        while (!stb && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'd0, stb}, 32'd1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input int m, input int v, input int p, input int n);
        mode   = 2'(m);
        verify = v[0];
        period = 24'(p);
        for (int k = 0; k < n; k++) begin
            exq.push_back(exp_write(m, k, p));
            if (v != 0 && m != 2) exq.push_back(exp_read());
        end
        @(negedge clk);
        en = 1'b1;
        wait_q_empty("run_drain", 200 + n * (p + 12) * 2);
        en = 1'b0;
        wait_busy_low("run_idle", 50);
        check("run_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int n;
        #12;
        check("rst_cyc", {31'd0, cyc}, 32'd0);
        check("rst_stb", {31'd0, stb}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pat", {26'd0, pat}, 32'd0);
        check("rst_err", {30'd0, err, code[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 0, 3, 7);
        run(1, 0, 1, 12);
        run(3, 0, 0, 65);
        run(2, 1, 2, 6);
        run(0, 1, 1, 4);
        for (int r = 0; r < 8; r++) begin
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 4)), int'($urandom_range(3, 12)));
        end

        // Read-back mismatch on the 0x04 write.
        corrupt = 1'b1;
        mode = 2'd0; verify = 1'b1; period = 24'd1;
        for (int k = 0; k < 3; k++) begin
            exq.push_back(exp_write(0, k, 1));
            exq.push_back(exp_read());
        end
        @(negedge clk);
        en = 1'b1;
        wait_q_empty("vfy_drain", 200);
        wait_busy_low("vfy_idle", 20);
        check("vfy_err", {31'd0, err}, 32'd1);
        check("vfy_code", {30'd0, code}, 32'd3);
        check("vfy_pat", {26'd0, pat}, 32'h04);
        en = 1'b0;
        corrupt = 1'b0;
        pulse_clr();
        check("vfy_clr", {30'd0, code}, 32'd0);

        // Ack timeout, then clear with enable still high.
        slv_mode = 1;
        mode = 2'd0; verify = 1'b0; period = 24'd2;
        @(negedge clk);
        en = 1'b1;
        wait_stb("tmo_stb", 20);
        n = 0;
        while (stb && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("tmo_stb_cycles", n, To);
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_code", {30'd0, code}, 32'd2);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        slv_mode = 0;
        exq.push_back(exp_write(0, 0, 2));
        pulse_clr();
        wait_q_empty("restart_drain", 50);
        en = 1'b0;
        wait_busy_low("restart_idle", 20);
        check("restart_err", {31'd0, err}, 32'd0);

        // Bus error on a write.
        slv_mode = 2;
        @(negedge clk);
        en = 1'b1;
        wait_stb("berr_stb", 20);
        wait_busy_low("berr_idle", 20);
        check("berr_err", {31'd0, err}, 32'd1);
        check("berr_code", {30'd0, code}, 32'd1);
        check("berr_pat", {26'd0, pat}, 32'h01);
        en = 1'b0;
        slv_mode = 0;
        pulse_clr();
        check("berr_clr", {31'd0, err}, 32'd0);

        // Disable while the write strobe is up: the cycle still completes.
        mode = 2'd2; verify = 1'b0; period = 24'd2;
        exq.push_back(exp_write(2, 0, 2));
        @(negedge clk);
        en = 1'b1;
        wait_stb("dis_stb", 20);
        en = 1'b0;
        wait_q_empty("dis_drain", 20);
        wait_busy_low("dis_idle", 20);
        @(negedge clk);
        check("dis_pat", {26'd0, pat}, 32'h3F);

        // Asynchronous reset in the middle of a strobe.
        mode = 2'd0;
        @(negedge clk);
        en = 1'b1;
        wait_stb("rst_mid_stb", 20);
        #1 rst_n = 1'b0;
        #1;
        check("arst_cyc", {31'd0, cyc}, 32'd0);
        check("arst_stb", {31'd0, stb}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_pat", {26'd0, pat}, 32'd0);
        check("arst_we", {31'd0, we}, 32'd0);
        check("arst_q", exq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
